apb4_master_arbiter: RTL and testbench
======================================

# apb4_master_arbiter

Round-robin APB4 master that shares one APB4 slave port (the `apb_slave_if` bus driven into the slave VIP) among `NREQ` local requesters. Each requester posts a single transfer with a valid/done handshake. The block then:
- arbitrates among pending requesters,
- sequences the APB SETUP/ACCESS phases,
- returns read data and error status,
- terminates transfers whose wait states exceed a programmable timeout.

## Interface
Parameters:
- `NREQ`, 4 — number of requesters (2..8)
- `AW`, 32 — address width
- `DW`, 32 — data width (multiple of 8)
- `TIMEOUT`, 16 — maximum consecutive ACCESS cycles with `PREADY` low; 0 disables the timeout

Ports:
- `PCLK` in 1 — clock; all logic on rising edge
- `PRESET` in 1 — synchronous, active-high reset
- `req_valid` in NREQ — requester i has a pending transfer
- `req_write` in NREQ — 1 = write, 0 = read
- `req_addr` in NREQ*AW — packed addresses; slice i = `[i*AW +: AW]`
- `req_wdata` in NREQ*DW — packed write data
- `req_strb` in NREQ*DW/8 — packed byte strobes
- `req_prot` in NREQ*3 — packed PPROT
- `rsp_done` out NREQ — one-hot, one-cycle completion pulse
- `rsp_rdata` out DW — read data, valid while any `rsp_done` bit is high
- `rsp_err` out 1 — `PSLVERR` or timeout, valid with `rsp_done`
- `rsp_timeout` out 1 — high with `rsp_done` when the transfer was terminated by timeout
- `PSEL`, `PENABLE`, `PWRITE` out 1 — APB4 master controls
- `PADDR` out AW
- `PWDATA` out DW
- `PSTRB` out DW/8
- `PPROT` out 3
- `PREADY`, `PSLVERR` in 1
- `PRDATA` in DW

## Operation
- Requester contract:
  - Assert `req_valid[i]` and hold all of its fields stable until `rsp_done[i]`.
  - Drop `req_valid[i]` in the `rsp_done[i]` cycle, or keep it high to post a new transfer.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - Candidates are `req_valid & ~rsp_done`; a requester is never re-granted in its own done cycle.
  - Pick the first candidate at or after `ptr`, searching upward with wrap-around.
  - On the edge, register the grant index g, latch its fields onto the APB outputs, set `PSEL=1`, and go to SETUP.
  - Set `ptr = g+1 mod NREQ`.
  - No candidate: stay in IDLE.
- SETUP: on the next edge set `PENABLE=1`, clear the wait counter, go to ACCESS.
- ACCESS with `PREADY=1`:
  - On the edge, pulse `rsp_done[g]`.
  - `rsp_rdata = PRDATA` for reads, 0 for writes.
  - `rsp_err = PSLVERR`, `rsp_timeout = 0`.
  - Clear `PSEL`/`PENABLE` and go to IDLE.
- ACCESS with `PREADY=0`:
  - Increment the wait counter, sized `$clog2(TIMEOUT+1)` with a minimum of 1 bit; it saturates and never wraps.
  - If `TIMEOUT != 0` and the counter reaches `TIMEOUT`, complete exactly as the ready case but with `rsp_err=1`, `rsp_timeout=1`, `rsp_rdata=0`.
- Reads drive `PSTRB=0` and `PWDATA=0` (APB4 rule).
- `PADDR`, `PWRITE`, `PWDATA`, `PSTRB`, `PPROT` are registered and held constant through SETUP and ACCESS; they are zeroed on return to IDLE.
- `PSLVERR`/`PRDATA` are sampled only in ACCESS when `PREADY=1`.

## Timing
- Reset values: all outputs 0; state IDLE; `ptr=0`; wait counter 0.
- Minimum latency, with `req_valid` sampled at edge E:
  - `PSEL=1` after E.
  - `PENABLE=1` after E+1.
  - If `PREADY=1` during ACCESS, `rsp_done` is high for exactly the cycle after E+2.
- Back-to-back transfers: at least one IDLE cycle (`PSEL=0`) between transfers. A new transfer's SETUP starts the cycle after `rsp_done`, so the throughput ceiling is one transfer per 3 cycles.
- Outputs are registered; no combinational path from `PREADY`/`PRDATA` to any output.
- Timeout, with `TIMEOUT=T` and `PREADY` held low: completion (`rsp_done`, `rsp_timeout`) is high in the cycle after the T-th ACCESS cycle. The slave may see `PSEL` drop without a ready; this is intended.
- `PRESET` during SETUP/ACCESS:
  - Transfer abandoned; no `rsp_done` for it.
  - Outputs return to reset values on that edge.
  - The requester must repost.
- `req_valid` deasserted by a requester mid-transfer is ignored; the transfer completes normally.
- Simultaneous requests are resolved by `ptr`. After reset, requester 0 has highest priority.

## Test plan
- Single read: `req_valid[1]=1`, addr 0x10, `PREADY=1`, `PRDATA=0xA5A5_0001` -> `PSEL` rises 1 cycle later, `PENABLE` 2 cycles later; `rsp_done=4'b0010` for one cycle, `rsp_rdata=0xA5A5_0001`, `rsp_err=0`, `PSTRB=0` during the read.
- Write with waits: `req_valid[0]`, write 0xDEAD_BEEF, strb 4'hF, `PREADY` low 3 ACCESS cycles then high -> `PADDR`/`PWDATA` stable for 5 cycles; `rsp_done[0]` once; `rsp_rdata=0`.
- Round-robin: all 4 requesters valid continuously -> grant order 0,1,2,3,0; exactly one IDLE cycle between transfers.
- Slave error: `PSLVERR=1` with `PREADY=1` on a read -> `rsp_err=1`, `rsp_timeout=0`, `rsp_done` one-hot for the granted requester.
- Timeout: `TIMEOUT=4`, `PREADY` stuck low -> after 4 ACCESS cycles `rsp_done`, `rsp_err=1`, `rsp_timeout=1`, `rsp_rdata=0`; `PSEL` drops; the next requester is granted normally.
- Reset mid-ACCESS: assert `PRESET` for 1 cycle while `PREADY=0` -> all outputs 0 next cycle; no `rsp_done`; after release, requester 0 wins over a simultaneous requester 2.

Source files
------------

// File: rtl/apb4_master_arbiter.sv
// Round-robin APB4 master sharing one slave port among NREQ requesters.
// IDLE -> SETUP -> ACCESS per transfer, with registered outputs and a wait-state timeout.
module apb4_master_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_write,
  input  logic [NREQ*AW-1:0]     req_addr,
  input  logic [NREQ*DW-1:0]     req_wdata,
  input  logic [NREQ*DW/8-1:0]   req_strb,
  input  logic [NREQ*3-1:0]      req_prot,
  output logic [NREQ-1:0]        rsp_done,
  output logic [DW-1:0]          rsp_rdata,
  output logic                   rsp_err,
  output logic                   rsp_timeout,
  output logic                   PSEL,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [AW-1:0]          PADDR,
  output logic [DW-1:0]          PWDATA,
  output logic [DW/8-1:0]        PSTRB,
  output logic [2:0]             PPROT,
  input  logic                   PREADY,
  input  logic                   PSLVERR,
  input  logic [DW-1:0]          PRDATA
);
  localparam int SW = DW / 8;
  localparam int PW = $clog2(NREQ);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   gnt_q, gnt_d;
  logic [CW-1:0]   wait_q, wait_d;
  logic            psel_q, psel_d;
  logic            penable_q, penable_d;
  logic            pwrite_q, pwrite_d;
  logic [AW-1:0]   paddr_q, paddr_d;
  logic [DW-1:0]   pwdata_q, pwdata_d;
  logic [SW-1:0]   pstrb_q, pstrb_d;
  logic [2:0]      pprot_q, pprot_d;
  logic [NREQ-1:0] rsp_done_q, rsp_done_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;
  logic            rsp_timeout_q, rsp_timeout_d;

  logic [NREQ-1:0] cand;
  logic            found;
  logic [PW-1:0]   pick;
  logic [PW-1:0]   scan_idx;
  logic [CW-1:0]   wait_inc;
  logic            timed_out;

  // A requester finishing this cycle is masked so it cannot be re-granted immediately.
  always_comb begin
    cand     = req_valid & ~rsp_done_q;
    found    = 1'b0;
    pick     = '0;
    scan_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      scan_idx = PW'((int'(ptr_q) + i) % NREQ);
      if (!found && cand[scan_idx]) begin
        found = 1'b1;
        pick  = scan_idx;
      end
    end
  end

  always_comb begin
    wait_inc  = (wait_q == {CW{1'b1}}) ? wait_q : wait_q + 1'b1;
    timed_out = (TIMEOUT != 0) && (wait_inc == CW'(TIMEOUT));
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    gnt_d         = gnt_q;
    wait_d        = wait_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    pprot_d       = pprot_q;
    rsp_done_d    = '0;
    rsp_rdata_d   = '0;
    rsp_err_d     = 1'b0;
    rsp_timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_d    = pick;
          ptr_d    = (pick == PW'(NREQ - 1)) ? '0 : pick + 1'b1;
          psel_d   = 1'b1;
          pwrite_d = req_write[pick];
          paddr_d  = req_addr[int'(pick)*AW +: AW];
          pwdata_d = req_write[pick] ? req_wdata[int'(pick)*DW +: DW] : '0;
          pstrb_d  = req_write[pick] ? req_strb[int'(pick)*SW +: SW] : '0;
          pprot_d  = req_prot[int'(pick)*3 +: 3];
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        wait_d    = '0;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        if (PREADY || timed_out) begin
          rsp_done_d[gnt_q] = 1'b1;
          if (PREADY) begin
            rsp_rdata_d = pwrite_q ? '0 : PRDATA;
            rsp_err_d   = PSLVERR;
          end else begin
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
          end
          psel_d    = 1'b0;
          penable_d = 1'b0;
          pwrite_d  = 1'b0;
          paddr_d   = '0;
          pwdata_d  = '0;
          pstrb_d   = '0;
          pprot_d   = '0;
          state_d   = S_IDLE;
        end else begin
          wait_d = wait_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      gnt_q         <= '0;
      wait_q        <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      pprot_q       <= '0;
      rsp_done_q    <= '0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      gnt_q         <= gnt_d;
      wait_q        <= wait_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      pprot_q       <= pprot_d;
      rsp_done_q    <= rsp_done_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign PSTRB       = pstrb_q;
  assign PPROT       = pprot_q;
  assign rsp_done    = rsp_done_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb4_master_arbiter.sv
// Bench for apb4_master_arbiter: directed scenarios plus randomized batches checked
// against a transaction-level round-robin model.
module tb_apb4_master_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TMO  = 4;

  logic                 PCLK = 1'b0;
  logic                 PRESET;
  logic [NREQ-1:0]      req_valid, req_write;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_wdata;
  logic [NREQ*DW/8-1:0] req_strb;
  logic [NREQ*3-1:0]    req_prot;
  logic [NREQ-1:0]      rsp_done;
  logic [DW-1:0]        rsp_rdata;
  logic                 rsp_err, rsp_timeout;
  logic                 PSEL, PENABLE, PWRITE;
  logic [AW-1:0]        PADDR;
  logic [DW-1:0]        PWDATA;
  logic [DW/8-1:0]      PSTRB;
  logic [2:0]           PPROT;
  logic                 PREADY, PSLVERR;
  logic [DW-1:0]        PRDATA;

  logic [AW-1:0]   f_addr  [NREQ];
  logic [DW-1:0]   f_wdata [NREQ];
  logic [DW/8-1:0] f_strb  [NREQ];
  logic [2:0]      f_prot  [NREQ];

  int total = 0;
  int bad   = 0;

  always #5 PCLK = ~PCLK;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW]       = f_addr[i];
      req_wdata[i*DW +: DW]      = f_wdata[i];
      req_strb[i*DW/8 +: DW/8]   = f_strb[i];
      req_prot[i*3 +: 3]         = f_prot[i];
    end
  end

  apb4_master_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
    .rsp_done(rsp_done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
  );

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic do_reset();
    PRESET = 1'b1; req_valid = '0; req_write = '0;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
    tick();
    PRESET = 1'b0;
  endtask

  task automatic test_reset();
    PRESET = 1'b1; req_valid = '1; PREADY = 1'b1;
    tick();
    total++; if ({PSEL, PENABLE, PWRITE} !== 3'b000) begin bad++; $display("FAIL rst_ctrl: got %b want 000", {PSEL, PENABLE, PWRITE}); end
    total++; if ({PADDR, PWDATA, PSTRB, PPROT} !== '0) begin bad++; $display("FAIL rst_bus: got %h want 0", {PADDR, PWDATA, PSTRB, PPROT}); end
    total++; if ({rsp_done, rsp_rdata, rsp_err, rsp_timeout} !== '0) begin bad++; $display("FAIL rst_rsp: got %h want 0", {rsp_done, rsp_rdata, rsp_err, rsp_timeout}); end
    tick();
    total++; if (PSEL !== 1'b0) begin bad++; $display("FAIL rst_hold_psel: got %b want 0", PSEL); end
    req_valid = '0; PREADY = 1'b0; PRESET = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    do_reset();
    f_addr[1] = 32'h10; req_write = '0; req_valid = 4'b0010;
    PREADY = 1'b1; PRDATA = 32'hA5A5_0001;
    tick();
    total++; if ({PSEL, PENABLE} !== 2'b10) begin bad++; $display("FAIL rd_setup: got %b want 10", {PSEL, PENABLE}); end
    total++; if (PADDR !== 32'h10 || PSTRB !== 4'h0 || PWRITE !== 1'b0) begin bad++; $display("FAIL rd_bus: addr %h strb %h wr %b want 10/0/0", PADDR, PSTRB, PWRITE); end
    tick();
    total++; if ({PSEL, PENABLE} !== 2'b11 || PSTRB !== 4'h0) begin bad++; $display("FAIL rd_access: got %b strb %h want 11/0", {PSEL, PENABLE}, PSTRB); end
    total++; if (rsp_done !== 4'b0000) begin bad++; $display("FAIL rd_early_done: got %b want 0000", rsp_done); end
    tick();
    total++; if (rsp_done !== 4'b0010) begin bad++; $display("FAIL rd_done: got %b want 0010", rsp_done); end
    total++; if (rsp_rdata !== 32'hA5A5_0001 || rsp_err !== 1'b0) begin bad++; $display("FAIL rd_data: got %h err %b want a5a50001/0", rsp_rdata, rsp_err); end
    total++; if (PSEL !== 1'b0) begin bad++; $display("FAIL rd_psel_drop: got %b want 0", PSEL); end
    req_valid = '0;
    tick();
    total++; if (rsp_done !== 4'b0000) begin bad++; $display("FAIL rd_done_pulse: got %b want 0000", rsp_done); end
  endtask

  task automatic test_write_waits();
    int stable = 0;
    do_reset();
    f_addr[0] = 32'h20; f_wdata[0] = 32'hDEAD_BEEF; f_strb[0] = 4'hF; f_prot[0] = 3'b010;
    req_write = 4'b0001; req_valid = 4'b0001; PREADY = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      if (k == 4) PREADY = 1'b1;
      if (PSEL && PENABLE == (k != 0) && PADDR == 32'h20 && PWDATA == 32'hDEAD_BEEF &&
          PSTRB == 4'hF && PPROT == 3'b010 && PWRITE && rsp_done == '0) stable++;
      tick();
    end
    total++; if (stable !== 5) begin bad++; $display("FAIL wr_stable: got %0d cycles want 5", stable); end
    total++; if (rsp_done !== 4'b0001) begin bad++; $display("FAIL wr_done: got %b want 0001", rsp_done); end
    total++; if (rsp_rdata !== '0 || rsp_err !== 1'b0) begin bad++; $display("FAIL wr_rsp: got %h err %b want 0/0", rsp_rdata, rsp_err); end
    req_valid = '0;
    tick();
    total++; if (rsp_done !== 4'b0000 || PSEL !== 1'b0) begin bad++; $display("FAIL wr_after: done %b psel %b want 0000/0", rsp_done, PSEL); end
  endtask

  task automatic test_round_robin();
    int cyc;
    do_reset();
    for (int i = 0; i < NREQ; i++) f_addr[i] = 32'h1000 + 32'(i);
    req_write = '0; req_valid = '1; PREADY = 1'b1;
    for (int n = 0; n < 5; n++) begin
      cyc = 0;
      do begin tick(); cyc++; end while (rsp_done == '0 && cyc < 10);
      total++; if (rsp_done !== 4'(1 << (n % NREQ))) begin bad++; $display("FAIL rr_order%0d: got %b want %b", n, rsp_done, 4'(1 << (n % NREQ))); end
      total++; if (cyc !== ((n == 0) ? 3 : 2) || PSEL !== 1'b0) begin bad++; $display("FAIL rr_timing%0d: got %0d cycles psel %b want %0d/0", n, cyc, PSEL, (n == 0) ? 3 : 2); end
      if (n == 4) req_valid = '0;
      tick();
      if (n < 4) begin
        total++; if (PSEL !== 1'b1 || PADDR !== 32'h1000 + 32'((n + 1) % NREQ)) begin bad++; $display("FAIL rr_next%0d: psel %b addr %h", n, PSEL, PADDR); end
      end
    end
  endtask

  task automatic test_slave_error();
    do_reset();
    f_addr[2] = 32'h40; req_write = '0; req_valid = 4'b0100;
    PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'h1234_5678;
    tick(); tick(); tick();
    total++; if (rsp_done !== 4'b0100) begin bad++; $display("FAIL err_done: got %b want 0100", rsp_done); end
    total++; if ({rsp_err, rsp_timeout} !== 2'b10 || rsp_rdata !== 32'h1234_5678) begin bad++; $display("FAIL err_flags: got %b data %h want 10/12345678", {rsp_err, rsp_timeout}, rsp_rdata); end
    req_valid = '0; PSLVERR = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int early = 0;
    do_reset();
    f_addr[1] = 32'h100; f_addr[3] = 32'h300; f_wdata[3] = 32'hCAFE_0003; f_strb[3] = 4'h3;
    req_write = 4'b1000; req_valid = 4'b1010; PREADY = 1'b0; PRDATA = '1;
    tick();
    total++; if (PADDR !== 32'h100 || PSEL !== 1'b1) begin bad++; $display("FAIL to_grant: addr %h psel %b want 100/1", PADDR, PSEL); end
    for (int k = 1; k <= TMO; k++) begin
      tick();
      if (rsp_done != '0 || !PSEL || !PENABLE) early++;
    end
    total++; if (early !== 0) begin bad++; $display("FAIL to_early: got %0d bad access cycles want 0", early); end
    tick();
    total++; if (rsp_done !== 4'b0010) begin bad++; $display("FAIL to_done: got %b want 0010", rsp_done); end
    total++; if ({rsp_err, rsp_timeout} !== 2'b11 || rsp_rdata !== '0 || PSEL !== 1'b0) begin bad++; $display("FAIL to_flags: got %b data %h psel %b want 11/0/0", {rsp_err, rsp_timeout}, rsp_rdata, PSEL); end
    req_valid = 4'b1000; PREADY = 1'b1;
    tick();
    total++; if (PSEL !== 1'b1 || PADDR !== 32'h300 || PWRITE !== 1'b1 || PWDATA !== 32'hCAFE_0003 || PSTRB !== 4'h3) begin bad++; $display("FAIL to_next: psel %b addr %h wr %b data %h strb %h", PSEL, PADDR, PWRITE, PWDATA, PSTRB); end
    tick(); tick();
    total++; if (rsp_done !== 4'b1000 || {rsp_err, rsp_timeout} !== 2'b00) begin bad++; $display("FAIL to_next_done: got %b flags %b want 1000/00", rsp_done, {rsp_err, rsp_timeout}); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    f_addr[0] = 32'hA0; f_addr[1] = 32'hB0; f_addr[2] = 32'hC0;
    req_write = '0; req_valid = 4'b0010; PREADY = 1'b0;
    tick(); tick();
    total++; if ({PSEL, PENABLE} !== 2'b11) begin bad++; $display("FAIL mr_access: got %b want 11", {PSEL, PENABLE}); end
    PRESET = 1'b1; req_valid = 4'b0101;
    tick();
    total++; if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT} !== '0) begin bad++; $display("FAIL mr_outputs: got %h want 0", {PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT}); end
    total++; if ({rsp_done, rsp_err, rsp_timeout} !== '0) begin bad++; $display("FAIL mr_rsp: got %b want 0", {rsp_done, rsp_err, rsp_timeout}); end
    PRESET = 1'b0;
    tick();
    total++; if (PSEL !== 1'b1 || PADDR !== 32'hA0) begin bad++; $display("FAIL mr_prio: psel %b addr %h want 1/a0", PSEL, PADDR); end
    PREADY = 1'b1;
    tick(); tick();
    total++; if (rsp_done !== 4'b0001) begin bad++; $display("FAIL mr_done0: got %b want 0001", rsp_done); end
    req_valid = 4'b0100;
    tick();
    total++; if (PADDR !== 32'hC0) begin bad++; $display("FAIL mr_next: addr %h want c0", PADDR); end
    tick(); tick();
    total++; if (rsp_done !== 4'b0100) begin bad++; $display("FAIL mr_done2: got %b want 0100", rsp_done); end
    req_valid = '0;
    tick();
  endtask

  // Each batch posts a random subset at once; the expected service order is the
  // subset visited circularly starting from the model's round-robin pointer.
  task automatic test_random();
    int m_ptr = 0;
    int exp_q[$];
    int g, waits, cyc;
    logic [NREQ-1:0] s;
    logic e_w, e_err;
    logic [DW-1:0] e_rd;
    do_reset();
    for (int b = 0; b < 25; b++) begin
      do s = NREQ'($urandom); while (s == '0);
      for (int i = 0; i < NREQ; i++) begin
        f_addr[i] = $urandom; f_wdata[i] = $urandom;
        f_strb[i] = 4'($urandom); f_prot[i] = 3'($urandom);
        req_write[i] = 1'($urandom);
      end
      exp_q.delete();
      for (int j = 0; j < NREQ; j++) if (s[(m_ptr + j) % NREQ]) exp_q.push_back((m_ptr + j) % NREQ);
      req_valid = s; PREADY = 1'b0; waits = 0; e_w = 1'b0; e_err = 1'b0; e_rd = '0;
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 100) begin
        tick(); cyc++;
        if (rsp_done != '0) begin
          g = exp_q.pop_front();
          total++; if (rsp_done !== 4'(1 << g)) begin bad++; $display("FAIL rnd_grant b%0d: got %b want %b", b, rsp_done, 4'(1 << g)); end
          total++; if ({rsp_rdata, rsp_err, rsp_timeout} !== {(e_w ? 32'h0 : e_rd), e_err, 1'b0}) begin bad++; $display("FAIL rnd_rsp b%0d: got %h/%b%b want %h/%b0", b, rsp_rdata, rsp_err, rsp_timeout, e_w ? 32'h0 : e_rd, e_err); end
          req_valid[g] = 1'b0; m_ptr = (g + 1) % NREQ; PREADY = 1'b0;
        end else if (PSEL && !PENABLE) begin
          g = exp_q[0];
          e_w = req_write[g];
          total++; if ({PADDR, PWRITE, PPROT} !== {f_addr[g], e_w, f_prot[g]}) begin bad++; $display("FAIL rnd_ctl b%0d: addr %h wr %b prot %h want %h/%b/%h", b, PADDR, PWRITE, PPROT, f_addr[g], e_w, f_prot[g]); end
          total++; if ({PWDATA, PSTRB} !== (e_w ? {f_wdata[g], f_strb[g]} : 36'h0)) begin bad++; $display("FAIL rnd_wdat b%0d: data %h strb %h", b, PWDATA, PSTRB); end
          waits = $urandom_range(0, TMO - 1); e_rd = $urandom; e_err = 1'($urandom);
          PRDATA = e_rd; PSLVERR = e_err; PREADY = (waits == 0);
        end else if (PSEL && PENABLE && !PREADY) begin
          waits--; PREADY = (waits == 0);
        end
      end
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rnd_stall b%0d: %0d transfers outstanding want 0", b, exp_q.size()); end
      req_valid = '0;
      tick();
    end
  endtask

  initial begin
    PRESET = 1'b1; req_valid = '0; req_write = '0;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
    for (int i = 0; i < NREQ; i++) begin f_addr[i] = '0; f_wdata[i] = '0; f_strb[i] = '0; f_prot[i] = '0; end
    test_reset();
    test_single_read();
    test_write_waits();
    test_round_robin();
    test_slave_error();
    test_timeout();
    test_reset_mid_access();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
